// File: rtl/bg_sched_pkg.sv
// Shared types and geometry for the background tile RAM write scheduler.
package bg_sched_pkg;

  localparam int TILE_COLS = 40;
  localparam int TILE_ROWS = 30;
  localparam int BG_DEPTH  = TILE_COLS * TILE_ROWS;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } sched_state_t;

  // Low 9 bits of a tile word; the upper bits are unused by the renderer.
  typedef struct packed {
    logic       enable;
    logic       yflip;
    logic       xflip;
    logic [2:0] row;
    logic [2:0] col;
  } tile_word_t;

endpackage

// File: rtl/bg_rr_picker.sv
// Combinational round-robin picker: first valid client at or above rr_ptr, wrapping mod NREQ.
module bg_rr_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && valid[PTR_W'(j)]) begin
        any                = 1'b1;
        grant[PTR_W'(j)]   = 1'b1;
        idx                = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/bg_write_scheduler.sv
// Shares the bg tile RAM write port between NREQ clients and runs a zero-fill clear sweep.
// Optional BG_SCHED_VBLANK_GATE_EN restricts all writes to video_on=0.
module bg_write_scheduler #(
  parameter int                NREQ      = 4,
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter int                TILE_COLS = 40,
  parameter int                TILE_ROWS = 30,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   clear_done,
  input  logic                   video_on,
  output logic                   addr_err,
  output logic                   bg_wea,
  output logic [ADDR_W-1:0]      bg_ram_addr,
  output logic [DATA_W-1:0]      bg_ram_data
);
  import bg_sched_pkg::*;

  localparam int                DEPTH    = TILE_COLS * TILE_ROWS;
  localparam int                PTR_W    = $clog2(NREQ);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [10:0]       CNT_LAST = 11'(DEPTH - 1);

  sched_state_t      state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [10:0]       clr_cnt_q, clr_cnt_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              addr_err_q, addr_err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic [NREQ-1:0]   pick_grant;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic              port_open;
  logic              in_range;
  logic              clr_last;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  bg_rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef BG_SCHED_VBLANK_GATE_EN
  assign port_open = !video_on;
`else
  wire unused_video_on = video_on;
  assign port_open = 1'b1;
`endif

  assign in_range = addr_arr[pick_idx] < DEPTH_A;
  assign clr_last = (clr_cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      clr_cnt_q  <= '0;
      wea_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      addr_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      wea_q      <= wea_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      addr_err_q <= addr_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // clear_start is accepted even during active video; the sweep itself waits for the port.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (clear_start) state_d = CLEAR;
      CLEAR:   if (port_open && clr_last) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    wea_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    addr_err_d = 1'b0;
    done_d     = 1'b0;
    req_ready  = '0;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          clr_cnt_d = '0;
        end else if (port_open && pick_any) begin
          // Out-of-range requests are consumed but never reach the RAM.
          req_ready  = pick_grant;
          rr_ptr_d   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
          addr_d     = addr_arr[pick_idx];
          data_d     = data_arr[pick_idx];
          wea_d      = in_range;
          addr_err_d = !in_range;
        end
      end
      CLEAR: begin
        if (port_open) begin
          wea_d  = 1'b1;
          addr_d = ADDR_W'(clr_cnt_q);
          data_d = CLEAR_VAL;
          if (clr_last) begin
            done_d    = 1'b1;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 11'd1;
          end
        end
      end
      default: ;
    endcase
    busy_d = (state_d == CLEAR);
  end

  assign bg_wea      = wea_q;
  assign bg_ram_addr = addr_q;
  assign bg_ram_data = data_q;
  assign addr_err    = addr_err_q;
  assign clear_busy  = busy_q;
  assign clear_done  = done_q;

endmodule
